mem_bus_decoder_n: RTL and testbench
====================================

Name: mem_bus_decoder_n

Overview:
- Parametrised 1-initiator / N-target memory bus decoder. Successor to the fixed 3-port bus arbiter.
- Adds a per-target base/mask address map and a registered decode stage.
- Adds an error response for unmapped addresses, a bus-timeout watchdog, and sticky error capture with an interrupt.
- Sits between the core's imem/dmem port and the RAM, GPIO and UART (or more) peripherals.

Parameters:
- N_TARGETS, 3, number of target ports (1..16).
- AW, 32, address width (equals RISCV_ADDR_WIDTH).
- DW, 32, data width (equals RISCV_WORD_WIDTH).
- BASE_ADDRS, {32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flat N_TARGETS*AW vector; target i occupies slice [i*AW +: AW].
- ADDR_MASKS, {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000}, flat N_TARGETS*AW vector of match masks.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for target ready; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, rdata value returned on any error response.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- s_valid_i  in  1  initiator request valid; held until s_ready_o.
- s_ready_o  out  1  one-cycle completion pulse.
- s_addr_i  in  AW  request address.
- s_wdata_i  in  DW  write data.
- s_we_i  in  4  byte write enables; 0 means read.
- s_rdata_o  out  DW  read data, valid while s_ready_o=1.
- s_err_o  out  1  error flag, qualified by s_ready_o.
- m_valid_o  out  N_TARGETS  per-target request valid; one-hot or zero.
- m_ready_i  in  N_TARGETS  per-target ready.
- m_addr_o  out  AW  request address, shared by all targets (latched copy).
- m_wdata_o  out  DW  write data, shared (latched).
- m_we_o  out  4  byte write enables, shared (latched).
- m_rdata_i  in  N_TARGETS*DW  per-target read data; target i at [i*DW +: DW].
- err_irq_o  out  1  sticky error interrupt.
- err_addr_o  out  AW  address of the first error since the last clear.
- err_clr_i  in  1  clears err_irq_o and err_addr_o.

Behaviour:
- Reset (asynchronous, rst_n=0), from any state including mid-transaction:
  - FSM returns to IDLE; the timeout counter clears.
  - All outputs go to 0: s_ready_o, s_err_o, s_rdata_o, m_valid_o, m_addr_o, m_wdata_o, m_we_o, err_irq_o, err_addr_o.
- Decode: target i matches when (s_addr_i & MASK[i]) == BASE[i]. The lowest matching index wins; no match means unmapped.
- State IDLE:
  - On s_valid_i=1, latch addr, wdata, we and the decoded index.
  - Go to ACCESS if mapped, or to ERR if unmapped.
  - m_valid_o stays 0 in IDLE, so decode latency is 1 cycle.
- State ACCESS:
  - m_valid_o[sel]=1; the shared m_* outputs are driven from the latches.
  - Timeout counter increments each cycle.
  - If m_ready_i[sel]=1: drop m_valid_o the next cycle and go to RESP with rdata captured from m_rdata_i[sel].
  - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: drop m_valid_o and go to ERR.
  - m_ready_i bits of non-selected targets are ignored.
- State RESP: s_ready_o=1 and s_err_o=0 for exactly 1 cycle, s_rdata_o = captured data; then go to DRAIN.
- State ERR: s_ready_o=1, s_err_o=1, s_rdata_o=ERR_DATA for 1 cycle; then go to DRAIN.
  - Capture the latched address into err_addr_o and set err_irq_o, only if err_irq_o is currently 0 (first error is kept).
- State DRAIN: one cycle with s_ready_o=0, ignoring s_valid_i (the initiator drops valid the cycle after ready); then go to IDLE.
- Throughput: the minimum transaction is 4 cycles (IDLE, ACCESS with immediate ready, RESP, DRAIN).
- err_clr_i=1 on the same cycle as an error capture: the capture wins, and err_irq_o stays 1 with the new address.
- s_rdata_o holds its last value outside response cycles; s_err_o is 0 outside response cycles.
- Writes complete exactly like reads; rdata is don't-care but still driven from the target.
- Mapped range width comes from the masks only; overlap resolution is the priority rule above.

Decomposition:
- Shared package/defines file mem_bus_defines.v holds:
  - FSM state encodings: IDLE, ACCESS, RESP, ERR, DRAIN.
  - The default ERR_DATA value.
  - Default map constants: RAM_BASE/MASK, GPIO_BASE/MASK, UART_BASE/MASK.
- One sub-module, mem_bus_addr_decode: combinational base/mask priority match producing the index plus a hit flag, parametrised by N_TARGETS/AW.

Test Plan:
- Read 0x0000_0010; target0 ready on its 2nd ACCESS cycle with rdata 0x1234_5678:
  - s_ready_o pulses exactly once with rdata 0x1234_5678 and s_err_o=0.
  - Only m_valid_o[0] is ever asserted.
- Write 0x1000_0004, we=4'hF, wdata 0xA5A5_A5A5: m_valid_o=3'b010, m_wdata_o=0xA5A5_A5A5, m_we_o=4'hF, then a single s_ready_o pulse.
- Read unmapped 0x3000_0000:
  - No m_valid_o is asserted.
  - s_ready_o=1, s_err_o=1, s_rdata_o=0xDEAD_BEEF.
  - err_irq_o=1, err_addr_o=0x3000_0000.
- TIMEOUT_CYCLES=8, target2 never ready:
  - m_valid_o[2] is high for exactly 8 cycles, then an error response.
  - err_addr_o = 0x2000_0000 request address.
- Second error at 0x4000_0000 before clear: err_addr_o remains 0x3000_0000. Pulse err_clr_i: irq=0, addr=0. Next error is captured.
- rst_n pulled low during ACCESS: all outputs are 0 immediately (asynchronously). After release, a new read to target0 completes normally.

Source files
------------

// File: rtl/mem_bus_decoder_n_pkg.sv
// Shared definitions for the N-target memory bus decoder: FSM states,
// error read-data and the default RAM/GPIO/UART address map.
package mem_bus_decoder_n_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_RESP   = 3'd2,
      ST_ERR    = 3'd3,
      ST_DRAIN  = 3'd4
   } bus_state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] GPIO_BASE = 32'h1000_0000;
   localparam logic [31:0] GPIO_MASK = 32'hFFFF_F000;
   localparam logic [31:0] UART_BASE = 32'h2000_0000;
   localparam logic [31:0] UART_MASK = 32'hFFFF_F000;

   // Target 0 sits in the lowest slice, so it is listed last.
   localparam logic [95:0] DEFAULT_BASE_ADDRS = {UART_BASE, GPIO_BASE, RAM_BASE};
   localparam logic [95:0] DEFAULT_ADDR_MASKS = {UART_MASK, GPIO_MASK, RAM_MASK};

endpackage

// File: rtl/mem_bus_addr_decode.sv
// Combinational base/mask address match; the lowest matching target index
// wins, and hit is low when no target claims the address.
module mem_bus_addr_decode #(
   parameter int N_TARGETS = 3,
   parameter int AW = 32,
   parameter logic [N_TARGETS*AW-1:0] BASE_ADDRS = '0,
   parameter logic [N_TARGETS*AW-1:0] ADDR_MASKS = '0,
   localparam int IW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
)(
   input  logic [AW-1:0] addr,
   output logic [IW-1:0] index,
   output logic          hit
);

   // Scanning from the top down lets lower indices overwrite higher ones.
   always_comb begin
      index = '0;
      hit   = 1'b0;
      for (int i = N_TARGETS - 1; i >= 0; i--) begin
         if ((addr & ADDR_MASKS[i*AW +: AW]) == BASE_ADDRS[i*AW +: AW]) begin
            index = IW'(i);
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_decoder_n.sv
// 1-initiator / N-target bus decoder with registered decode, error response
// for unmapped addresses, ready watchdog and sticky first-error capture.
module mem_bus_decoder_n
   import mem_bus_decoder_n_pkg::*;
#(
   parameter int N_TARGETS = 3,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter logic [N_TARGETS*AW-1:0] BASE_ADDRS = DEFAULT_BASE_ADDRS,
   parameter logic [N_TARGETS*AW-1:0] ADDR_MASKS = DEFAULT_ADDR_MASKS,
   parameter int TIMEOUT_CYCLES = 255,
   parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   input  logic [AW-1:0]          s_addr_i,
   input  logic [DW-1:0]          s_wdata_i,
   input  logic [3:0]             s_we_i,
   output logic [DW-1:0]          s_rdata_o,
   output logic                   s_err_o,
   output logic [N_TARGETS-1:0]   m_valid_o,
   input  logic [N_TARGETS-1:0]   m_ready_i,
   output logic [AW-1:0]          m_addr_o,
   output logic [DW-1:0]          m_wdata_o,
   output logic [3:0]             m_we_o,
   input  logic [N_TARGETS*DW-1:0] m_rdata_i,
   output logic                   err_irq_o,
   output logic [AW-1:0]          err_addr_o,
   input  logic                   err_clr_i
);

   localparam int IW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   bus_state_e    state_q, state_d;
   logic [IW-1:0] sel_q;
   logic [IW-1:0] dec_index;
   logic          dec_hit;
   logic [CW-1:0] cnt_q;
   logic          sel_ready;
   logic          timeout_hit;

   mem_bus_addr_decode #(
      .N_TARGETS (N_TARGETS),
      .AW        (AW),
      .BASE_ADDRS(BASE_ADDRS),
      .ADDR_MASKS(ADDR_MASKS)
   ) u_decode (
      .addr (s_addr_i),
      .index(dec_index),
      .hit  (dec_hit)
   );

   assign sel_ready = m_ready_i[sel_q];

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
         assign timeout_hit = 1'b0;
      end else begin : g_watchdog
         assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ready from the selected target takes priority over an expiring watchdog.
   always_comb begin
      state_d   = state_q;
      m_valid_o = '0;
      s_ready_o = 1'b0;
      s_err_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_valid_i) begin
               state_d = dec_hit ? ST_ACCESS : ST_ERR;
            end
         end
         ST_ACCESS: begin
            m_valid_o[sel_q] = 1'b1;
            if (sel_ready) begin
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_RESP: begin
            s_ready_o = 1'b1;
            state_d   = ST_DRAIN;
         end
         ST_ERR: begin
            s_ready_o = 1'b1;
            s_err_o   = 1'b1;
            state_d   = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request latches double as the shared m_* outputs; response data is
   // loaded on the way into RESP/ERR so it holds until the next response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_addr_o  <= '0;
         m_wdata_o <= '0;
         m_we_o    <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         s_rdata_o <= '0;
      end else begin
         if (state_q == ST_IDLE && s_valid_i) begin
            m_addr_o  <= s_addr_i;
            m_wdata_o <= s_wdata_i;
            m_we_o    <= s_we_i;
            sel_q     <= dec_index;
         end
         if (state_q == ST_ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end
         if (state_d == ST_RESP) begin
            s_rdata_o <= m_rdata_i[sel_q*DW +: DW];
         end else if (state_d == ST_ERR) begin
            s_rdata_o <= ERR_DATA;
         end
      end
   end

   // A capture in the same cycle as a clear wins and records the new address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_irq_o  <= 1'b0;
         err_addr_o <= '0;
      end else begin
         if (state_q == ST_ERR && (!err_irq_o || err_clr_i)) begin
            err_irq_o  <= 1'b1;
            err_addr_o <= m_addr_o;
         end else if (err_clr_i) begin
            err_irq_o  <= 1'b0;
            err_addr_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_decoder_n.sv
// Self-checking bench for mem_bus_decoder_n: directed and random transactions
// compared against an address-map/latency reference model.
module tb_mem_bus_decoder_n;

   localparam int N   = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            s_valid_i = 1'b0;
   logic            s_ready_o;
   logic [AW-1:0]   s_addr_i = '0;
   logic [DW-1:0]   s_wdata_i = '0;
   logic [3:0]      s_we_i = '0;
   logic [DW-1:0]   s_rdata_o;
   logic            s_err_o;
   logic [N-1:0]    m_valid_o;
   logic [N-1:0]    m_ready_i = '0;
   logic [AW-1:0]   m_addr_o;
   logic [DW-1:0]   m_wdata_o;
   logic [3:0]      m_we_o;
   logic [N*DW-1:0] m_rdata_i = '0;
   logic            err_irq_o;
   logic [AW-1:0]   err_addr_o;
   logic            err_clr_i = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] bases [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
   logic [31:0] masks [N] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000};

   logic        model_irq = 1'b0;
   logic [31:0] model_err_addr = '0;

   mem_bus_decoder_n #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_addr_i  (s_addr_i),
      .s_wdata_i (s_wdata_i),
      .s_we_i    (s_we_i),
      .s_rdata_o (s_rdata_o),
      .s_err_o   (s_err_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_addr_o  (m_addr_o),
      .m_wdata_o (m_wdata_o),
      .m_we_o    (m_we_o),
      .m_rdata_i (m_rdata_i),
      .err_irq_o (err_irq_o),
      .err_addr_o(err_addr_o),
      .err_clr_i (err_clr_i)
   );

   always #5 clk = ~clk;

   function automatic int refTarget(input logic [31:0] a);
      for (int i = 0; i < N; i++) begin
         if ((a & masks[i]) == bases[i]) return i;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction; lat is the ACCESS cycle on which the selected
   // target raises ready (0 = never).
   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we,
                                input logic [31:0] wdata, input int lat,
                                input logic [31:0] tdata, input logic clr_on_err);
      int          tgt, exp_acc, acc, pulses, bad_valid;
      logic        exp_err, done, got_err;
      logic [31:0] got_rdata, seen_addr, seen_wdata;
      logic [3:0]  seen_we;
      logic [N-1:0] exp_mv;

      tgt    = refTarget(addr);
      exp_mv = '0;
      if (tgt < 0) begin
         exp_err = 1'b1;
         exp_acc = 0;
      end else begin
         exp_mv[tgt] = 1'b1;
         if (lat >= 1 && lat <= TMO) begin
            exp_err = 1'b0;
            exp_acc = lat;
         end else begin
            exp_err = 1'b1;
            exp_acc = TMO;
         end
      end

      @(negedge clk);
      s_addr_i  = addr;
      s_we_i    = we;
      s_wdata_i = wdata;
      s_valid_i = 1'b1;
      acc = 0; pulses = 0; bad_valid = 0; done = 1'b0; got_err = 1'b0;
      got_rdata = '0; seen_addr = '0; seen_wdata = '0; seen_we = '0;

      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         err_clr_i = 1'b0;
         for (int i = 0; i < N; i++) m_rdata_i[i*DW +: DW] = $urandom;
         m_ready_i = N'($urandom);
         if (tgt >= 0) begin
            m_ready_i[tgt] = 1'b0;
            m_rdata_i[tgt*DW +: DW] = tdata;
         end
         if (m_valid_o != '0) begin
            acc++;
            if (m_valid_o !== exp_mv) bad_valid++;
            seen_addr  = m_addr_o;
            seen_wdata = m_wdata_o;
            seen_we    = m_we_o;
            if (tgt >= 0 && acc == lat) m_ready_i[tgt] = 1'b1;
         end
         if (s_ready_o) begin
            pulses++;
            got_rdata = s_rdata_o;
            got_err   = s_err_o;
            s_valid_i = 1'b0;
            done      = 1'b1;
            if (clr_on_err && s_err_o) err_clr_i = 1'b1;
         end
      end
      checkOutput("txn_completed", done, 1);

      @(negedge clk);
      err_clr_i = 1'b0;
      m_ready_i = '0;
      if (s_ready_o) pulses++;
      if (m_valid_o != '0) bad_valid++;

      if (exp_err && (!model_irq || clr_on_err)) begin
         model_irq      = 1'b1;
         model_err_addr = addr;
      end

      checkOutput("ready_pulses", pulses, 1);
      checkOutput("access_cycles", acc, exp_acc);
      checkOutput("valid_onehot", bad_valid, 0);
      checkOutput("resp_err", got_err, exp_err);
      checkOutput("resp_rdata", got_rdata, exp_err ? 32'hDEAD_BEEF : tdata);
      checkOutput("drain_err_low", s_err_o, 0);
      if (tgt >= 0) begin
         checkOutput("m_addr", seen_addr, addr);
         checkOutput("m_wdata", seen_wdata, wdata);
         checkOutput("m_we", seen_we, we);
      end
      checkOutput("err_irq", err_irq_o, model_irq);
      checkOutput("err_addr", err_addr_o, model_err_addr);
   endtask

   task automatic clearErrors;
      @(negedge clk);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      model_irq      = 1'b0;
      model_err_addr = '0;
      checkOutput("clr_irq", err_irq_o, model_irq);
      checkOutput("clr_addr", err_addr_o, model_err_addr);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_s_ready"}, s_ready_o, 0);
      checkOutput({tag, "_s_err"}, s_err_o, 0);
      checkOutput({tag, "_s_rdata"}, s_rdata_o, 0);
      checkOutput({tag, "_m_valid"}, m_valid_o, 0);
      checkOutput({tag, "_m_addr"}, m_addr_o, 0);
      checkOutput({tag, "_m_wdata"}, m_wdata_o, 0);
      checkOutput({tag, "_m_we"}, m_we_o, 0);
      checkOutput({tag, "_err_irq"}, err_irq_o, 0);
      checkOutput({tag, "_err_addr"}, err_addr_o, 0);
   endtask

   initial begin
      int          pick;
      logic [31:0] raddr;

      #3;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(32'h0000_0010, 4'h0, 32'h0, 2, 32'h1234_5678, 1'b0);
      applyStimulus(32'h1000_0004, 4'hF, 32'hA5A5_A5A5, 1, $urandom, 1'b0);
      applyStimulus(32'h3000_0000, 4'h0, 32'h0, 1, $urandom, 1'b0);
      applyStimulus(32'h4000_0000, 4'h0, 32'h0, 1, $urandom, 1'b0);
      clearErrors();
      applyStimulus(32'h2000_0000, 4'h0, 32'h0, 0, $urandom, 1'b0);
      applyStimulus(32'h5000_0000, 4'h0, 32'h0, 1, $urandom, 1'b1);
      applyStimulus(32'h2000_0FFC, 4'h3, 32'h0BAD_F00D, TMO, $urandom, 1'b0);
      clearErrors();

      for (int k = 0; k < 30; k++) begin
         pick = $urandom_range(0, 3);
         if (pick < N) raddr = bases[pick] | ($urandom & ~masks[pick]);
         else          raddr = $urandom;
         applyStimulus(raddr, 4'($urandom), $urandom, $urandom_range(0, 10),
                       $urandom, ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 4) == 0) clearErrors();
      end

      applyStimulus(32'h6000_0000, 4'h0, 32'h0, 1, $urandom, 1'b0);
      @(negedge clk);
      s_addr_i  = 32'h0000_0020;
      s_we_i    = 4'h3;
      s_wdata_i = 32'h1357_9BDF;
      s_valid_i = 1'b1;
      m_ready_i = '0;
      @(negedge clk);
      checkOutput("pre_reset_valid", m_valid_o, 3'b001);
      #2 rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      s_valid_i = 1'b0;
      model_irq      = 1'b0;
      model_err_addr = '0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h0000_0044, 4'h0, 32'h0, 1, 32'hCAFE_0044, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
